// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM states, control-output bundle and the RUN decode.
// The optional HAZARD_PERF_EN counters live in hazard_ctrl.sv.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic ifidFlush;
        logic idexFlush;
        logic exmemWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                      idexFlush: 1'b0, exmemWrite: 1'b0};
    localparam ctrl_t CTRL_RESET  = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b1,
                                      idexFlush: 1'b1, exmemWrite: 1'b0};
    localparam ctrl_t CTRL_RUN    = '{pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0,
                                      idexFlush: 1'b0, exmemWrite: 1'b1};
    localparam ctrl_t CTRL_REDIR  = '{pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b1,
                                      idexFlush: 1'b1, exmemWrite: 1'b1};
    localparam ctrl_t CTRL_STALL  = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                      idexFlush: 1'b1, exmemWrite: 1'b1};

    // Redirect outranks load-use: the dependent instruction is on the wrong path.
    function automatic ctrl_t run_decode(input logic freeze, input logic redirect,
                                         input logic loadUse);
        if (freeze)
            return CTRL_FREEZE;
        else if (redirect)
            return CTRL_REDIR;
        else if (loadUse)
            return CTRL_STALL;
        else
            return CTRL_RUN;
    endfunction

endpackage

// File: rtl/hazard_ctrl_loaduse_det.sv
// Combinational load-use detector: a load in EX whose rd feeds a source of the ID instruction.
// Writes to x0 never create a dependency.
module hazard_loaduse_det
    import hazard_ctrl_pkg::*;
(
    input  logic       i_idRs1,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_idRs2,
    input  logic       i_memRead,
    input  logic [4:0] i_rd,
    output logic       o_loadUse
);
    logic w_hit1;
    logic w_hit2;

    assign w_hit1    = i_idRs1 && (i_rs1 == i_rd);
    assign w_hit2    = i_idRs2 && (i_rs2 == i_rd);
    assign o_loadUse = i_memRead && (i_rd != REG_ZERO) && (w_hit1 || w_hit2);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, redirect flush and data-memory freeze with timeout.
// Define HAZARD_PERF_EN to add stallCnt/flushCnt/waitCnt_total performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idRs1,
    input  logic [4:0]  idRs2,
    input  logic        idUsesRs1,
    input  logic        idUsesRs2,
    input  logic        idexMemRead,
    input  logic [4:0]  idexRegrd,
    input  logic        exRedirect,
    input  logic        exmemMemReq,
    input  logic        dmemReady,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        exmemWrite,
    output logic        memErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt,
    output logic [31:0] waitCnt_total
`endif
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_waitCntNext;
    logic             w_freeze;
    logic             w_loadUse;
    ctrl_t            w_ctrl;

    assign w_freeze = exmemMemReq && !dmemReady;

    hazard_loaduse_det u_det (
        .i_idRs1   (idUsesRs1),
        .i_rs1     (idRs1),
        .i_rs2     (idRs2),
        .i_idRs2   (idUsesRs2),
        .i_memRead (idexMemRead),
        .i_rd      (idexRegrd),
        .o_loadUse (w_loadUse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_next;
            r_waitCnt <= w_waitCntNext;
        end
    end

    // The RUN-state freeze cycle is the first wait cycle, hence the count starts at 1.
    always_comb begin
        w_next        = r_state;
        w_waitCntNext = r_waitCnt;
        case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_next        = MEMWAIT;
                    w_waitCntNext = CNT_W'(1);
                end
            end
            MEMWAIT: begin
                if (dmemReady) begin
                    w_next        = RUN;
                    w_waitCntNext = '0;
                end else if (r_waitCnt == CNT_W'(TIMEOUT)) begin
                    w_next = ERROR;
                end else begin
                    w_waitCntNext = r_waitCnt + CNT_W'(1);
                end
            end
            ERROR:   w_next = ERROR;
            default: w_next = RUN;
        endcase
    end

    always_comb begin
        w_ctrl = CTRL_FREEZE;
        memErr = 1'b0;
        if (rst) begin
            w_ctrl = CTRL_RESET;
        end else begin
            case (r_state)
                RUN:     w_ctrl = run_decode(w_freeze, exRedirect, w_loadUse);
                MEMWAIT: w_ctrl = run_decode(!dmemReady, exRedirect, w_loadUse);
                ERROR: begin
                    w_ctrl = CTRL_FREEZE;
                    memErr = 1'b1;
                end
                default: w_ctrl = CTRL_FREEZE;
            endcase
        end
    end

    assign pcWrite    = w_ctrl.pcWrite;
    assign ifidWrite  = w_ctrl.ifidWrite;
    assign ifidFlush  = w_ctrl.ifidFlush;
    assign idexFlush  = w_ctrl.idexFlush;
    assign exmemWrite = w_ctrl.exmemWrite;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_flushCnt;
    logic [31:0] r_waitTotal;
    logic        w_isStall;
    logic        w_isFlush;
    logic        w_isFreeze;

    // Event class is recovered from the decoded bundle; rst is low whenever these are sampled.
    assign w_isStall  = w_ctrl.idexFlush && !w_ctrl.ifidFlush;
    assign w_isFlush  = w_ctrl.ifidFlush;
    assign w_isFreeze = !w_ctrl.exmemWrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt  <= '0;
            r_flushCnt  <= '0;
            r_waitTotal <= '0;
        end else if (r_state != ERROR) begin
            if (w_isStall)  r_stallCnt  <= r_stallCnt + 32'd1;
            if (w_isFlush)  r_flushCnt  <= r_flushCnt + 32'd1;
            if (w_isFreeze) r_waitTotal <= r_waitTotal + 32'd1;
        end
    end

    assign stallCnt      = r_stallCnt;
    assign flushCnt      = r_flushCnt;
    assign waitCnt_total = r_waitTotal;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4; the HAZARD_PERF_EN counters are checked when defined.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  idRs1, idRs2, idexRegrd;
    logic        idUsesRs1, idUsesRs2, idexMemRead, exRedirect, exmemMemReq, dmemReady;
    logic        pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, memErr;
`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt, flushCnt, waitCnt_total;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Bundle order: pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite
    localparam logic [4:0] O_RST = 5'b00110;
    localparam logic [4:0] O_RUN = 5'b11001;
    localparam logic [4:0] O_FRZ = 5'b00000;
    localparam logic [4:0] O_RED = 5'b11111;
    localparam logic [4:0] O_STL = 5'b00011;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .idRs1       (idRs1),
        .idRs2       (idRs2),
        .idUsesRs1   (idUsesRs1),
        .idUsesRs2   (idUsesRs2),
        .idexMemRead (idexMemRead),
        .idexRegrd   (idexRegrd),
        .exRedirect  (exRedirect),
        .exmemMemReq (exmemMemReq),
        .dmemReady   (dmemReady),
        .pcWrite     (pcWrite),
        .ifidWrite   (ifidWrite),
        .ifidFlush   (ifidFlush),
        .idexFlush   (idexFlush),
        .exmemWrite  (exmemWrite),
        .memErr      (memErr)
`ifdef HAZARD_PERF_EN
        ,
        .stallCnt      (stallCnt),
        .flushCnt      (flushCnt),
        .waitCnt_total (waitCnt_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        idRs1 = 5'd0; idRs2 = 5'd0; idexRegrd = 5'd0;
        idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; idexMemRead = 1'b0;
        exRedirect = 1'b0; exmemMemReq = 1'b0; dmemReady = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("reset_outs", outs(), {27'd0, O_RST});
        chk("reset_memerr", {31'd0, memErr}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("run_idle", outs(), {27'd0, O_RUN});

        // Load-use on rs1, then the load leaves EX
        idexMemRead = 1'b1; idexRegrd = 5'd5; idRs1 = 5'd5; idUsesRs1 = 1'b1;
        #1;
        chk("lu_rs1", outs(), {27'd0, O_STL});
        tick();
        idexMemRead = 1'b0; idexRegrd = 5'd0;
        #1;
        chk("lu_release", outs(), {27'd0, O_RUN});

        // Load-use on rs2, and a matching rs1 that is not actually read
        idexMemRead = 1'b1; idexRegrd = 5'd7; idRs1 = 5'd3; idUsesRs1 = 1'b1;
        idRs2 = 5'd7; idUsesRs2 = 1'b1;
        #1;
        chk("lu_rs2", outs(), {27'd0, O_STL});
        idUsesRs2 = 1'b0; idRs1 = 5'd7; idUsesRs1 = 1'b0;
        #1;
        chk("lu_unused_src", outs(), {27'd0, O_RUN});

        // Load to x0 never stalls
        idexRegrd = 5'd0; idRs1 = 5'd0; idUsesRs1 = 1'b1;
        #1;
        chk("lu_x0", outs(), {27'd0, O_RUN});
        tick();

        // Redirect together with a load-use condition
        idexRegrd = 5'd5; idRs1 = 5'd5; exRedirect = 1'b1;
        #1;
        chk("redir_over_lu", outs(), {27'd0, O_RED});
        tick();
        idle_inputs();

        // Memory wait: three frozen cycles, then release
        exmemMemReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("memwait_frz%0d", i), outs(), {27'd0, O_FRZ});
            tick();
        end
        dmemReady = 1'b1;
        #1;
        chk("memwait_release", outs(), {27'd0, O_RUN});
        tick();
        exmemMemReq = 1'b0; dmemReady = 1'b0;
        #1;
        chk("memwait_back_run", outs(), {27'd0, O_RUN});

        // Held redirect flushes only on the release cycle
        exmemMemReq = 1'b1; exRedirect = 1'b1;
        tick();
        #1;
        chk("redir_held_frz", outs(), {27'd0, O_FRZ});
        dmemReady = 1'b1;
        #1;
        chk("redir_held_release", outs(), {27'd0, O_RED});
        tick();
        idle_inputs();

        // Ready in the request cycle: no freeze, no MEMWAIT afterwards
        exmemMemReq = 1'b1; dmemReady = 1'b1;
        #1;
        chk("same_cycle_ready", outs(), {27'd0, O_RUN});
        tick();
        idle_inputs();
        #1;
        chk("same_cycle_no_wait", outs(), {27'd0, O_RUN});

        // Timeout: ERROR after the 5th frozen cycle
        exmemMemReq = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk($sformatf("to_frz%0d", i), outs(), {27'd0, O_FRZ});
            chk($sformatf("to_noerr%0d", i), {31'd0, memErr}, 32'd0);
            tick();
        end
        #1;
        chk("to_memerr", {31'd0, memErr}, 32'd1);
        dmemReady = 1'b1; exRedirect = 1'b1;
        tick(); tick();
        chk("err_sticky", {31'd0, memErr}, 32'd1);
        chk("err_frozen", outs(), {27'd0, O_FRZ});

        // Reset clears ERROR
        rst = 1'b1;
        #1;
        chk("err_rst_outs", outs(), {27'd0, O_RST});
        chk("err_rst_memerr", {31'd0, memErr}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("err_rst_run", outs(), {27'd0, O_RUN});
        tick();

        // Async reset mid-MEMWAIT, away from any clock edge
        exmemMemReq = 1'b1;
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mw_rst_outs", outs(), {27'd0, O_RST});
        rst = 1'b0;
        exmemMemReq = 1'b0;
        #1;
        chk("mw_rst_run", outs(), {27'd0, O_RUN});
        chk("mw_rst_memerr", {31'd0, memErr}, 32'd0);
`ifdef HAZARD_PERF_EN
        chk("perf_rst_stall", stallCnt, 32'd0);
        chk("perf_rst_flush", flushCnt, 32'd0);
        chk("perf_rst_wait", waitCnt_total, 32'd0);
        tick();
        idexMemRead = 1'b1; idexRegrd = 5'd9; idRs2 = 5'd9; idUsesRs2 = 1'b1;
        tick();
        idle_inputs();
        exRedirect = 1'b1;
        tick();
        idle_inputs();
        exmemMemReq = 1'b1;
        tick(); tick();
        dmemReady = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("perf_stall", stallCnt, 32'd1);
        chk("perf_flush", flushCnt, 32'd1);
        chk("perf_wait", waitCnt_total, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
